board_port_arbiter: RTL and testbench
=====================================

// Module: board_port_arbiter
// PURPOSE
//  Shares the single control-side read/write port (addr1/write_data1/read_data1/w_nr) of one board_mem among N_REQ requesters.
//  Requesters are 0 = main game FSM, 1 = ship-placement handler, 2 = ship-counter scanner.
//  Round-robin single-beat arbitration, plus a lock for read-modify-write sequences.
//  One instance per board (my/enemy), in the control_clk domain, between the requesters and board_mem port 1.
// PARAMETERS
//  N_REQ      3   number of requesters (2..8)
//  X_SIZE     12  valid columns; addr[3:0] = x
//  Y_SIZE     12  valid rows; addr[7:4] = y
//  MAX_LOCK   16  max cycles a lock may hold the port before forced release
// PORTS
//  clk        in   1          control clock
//  rst        in   1          asynchronous, active-low reset
//  req        in   N_REQ      per-requester access request, held until gnt
//  lock       in   N_REQ      keep ownership after the current beat (RMW)
//  w_nr       in   N_REQ      1 = write, 0 = read
//  addr       in   8*N_REQ    {y,x} cell address; slice i = [8i+7:8i]
//  wdata      in   2*N_REQ    write data, slice i = [2i+1:2i]
//  gnt        out  N_REQ      one-hot, 1-cycle pulse: beat issued this cycle
//  rvalid     out  N_REQ      one-hot pulse, cycle after a read gnt
//  rdata      out  2          read data, valid with rvalid
//  err        out  N_REQ      pulse with gnt when addr is out of range
//  mem_addr   out  8          to board_mem addr1
//  mem_wdata  out  2          to board_mem write_data1
//  mem_w_nr   out  1          to board_mem w_nr
//  mem_rdata  in   2          from board_mem read_data1 (1-cycle read latency)
// BEHAVIOUR
//  Reset values
//   - gnt=0, rvalid=0, err=0, rdata=0, mem_addr=0, mem_wdata=0, mem_w_nr=0.
//   - rr_ptr=0, state=IDLE, lock_ctr=0.
//  Memory port: mem_* is driven combinationally from the granted requester.
//   - When no beat is issued: mem_w_nr=0 (never a spurious write) and mem_addr holds its last value.
//  FSM states
//   - IDLE: no owner.
//     - If any req: owner = first set req searching from rr_ptr upward, with wrap.
//     - Issue beat: gnt[owner]=1. Go OWN if lock[owner], else stay IDLE.
//     - rr_ptr = owner+1 mod N_REQ.
//   - OWN: only the owner is served; req[owner] -> gnt[owner] each cycle.
//     - lock_ctr increments every OWN cycle.
//     - Exit to IDLE when lock[owner]=0, or when lock_ctr reaches MAX_LOCK-1.
//     - On the exit cycle arbitration as in IDLE happens in the same cycle (no dead cycle).
//     - lock_ctr clears on exit.
//  Read: rvalid[i] and rdata = mem_rdata are registered one cycle after gnt[i] with w_nr[i]=0.
//   - Back-to-back reads give rvalid on consecutive cycles.
//  Write: takes effect in board_mem on the gnt cycle. No rvalid.
//  Range check: x>=X_SIZE or y>=Y_SIZE.
//   - Beat still consumes gnt, err[i] pulses.
//   - mem_w_nr forced 0.
//   - For a read, rvalid still pulses with rdata=0.
//  Fairness: a requester with req held is granted within N_REQ-1 beats plus at most one lock of MAX_LOCK cycles.
//  Edge cases
//   - req deasserted by the owner in OWN: no beat that cycle; still owner while lock=1.
//   - lock asserted without req in IDLE: ignored.
//  Reset mid-transaction: all outputs return to reset values immediately (async); the pending rvalid is lost.
//  Requester slices i >= N_REQ do not exist; rr_ptr width = $clog2(N_REQ).
// STRUCTURE
//  warships_pkg
//   - typedef enum logic {IDLE, OWN} arb_state_t.
//   - localparam BOARD_ADDR_W=8, CELL_W=2.
//  Sub-module rr_pick #(N)
//   - Combinational round-robin priority picker: inputs req, ptr; outputs onehot, idx.
//   - Reusable by the future mouse/event arbiter.
// TESTING
//  1. Reset held, req=3'b111 -> gnt=0, mem_w_nr=0. Release -> gnt=001, then 010, then 100, then 001.
//  2. Req0 write addr 8'h23 wdata 2'b10, then req1 read 8'h23 -> rvalid[1] one cycle after gnt[1], rdata=2'b10.
//  3. Req0 lock=1 for a read then a write of 8'h45, req1 held throughout
//     -> no gnt[1] until lock drops; gnt[1] on the release cycle.
//  4. Lock held forever by req2, MAX_LOCK=16 -> forced release after 16 OWN cycles; req0/req1 then granted.
//  5. Write to 8'hC0 (y=12) -> err pulse, mem_w_nr stays 0, cell 8'hC0 unchanged.
//     Read of 8'h0C -> rvalid with rdata=0.
//  6. Async reset mid-OWN with a read pending -> no rvalid; state IDLE; rr_ptr=0 on release.

Source files
------------

// File: rtl/warships_pkg.sv
// Shared types and widths for the warships board-memory control path.
package warships_pkg;

    typedef enum logic {IDLE, OWN} arb_state_t;

    localparam int BOARD_ADDR_W = 8;
    localparam int CELL_W       = 2;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req at or above ptr, with wrap.
module rr_pick #(
    parameter int N  = 3,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx
);

    logic found;
    int   cand;

    always_comb begin
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        cand   = 0;
        for (int k = 0; k < N; k++) begin
            cand = int'(ptr) + k;
            if (cand >= N) cand = cand - N;
            if (!found && req[cand]) begin
                found        = 1'b1;
                onehot[cand] = 1'b1;
                idx          = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/board_port_arbiter.sv
// Shares board_mem port 1 among N_REQ requesters: round-robin single beats,
// with a bounded lock so one requester can complete a read-modify-write.
module board_port_arbiter
    import warships_pkg::*;
#(
    parameter int N_REQ    = 3,
    parameter int X_SIZE   = 12,
    parameter int Y_SIZE   = 12,
    parameter int MAX_LOCK = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_REQ-1:0]              req,
    input  logic [N_REQ-1:0]              lock,
    input  logic [N_REQ-1:0]              w_nr,
    input  logic [BOARD_ADDR_W*N_REQ-1:0] addr,
    input  logic [CELL_W*N_REQ-1:0]       wdata,
    output logic [N_REQ-1:0]              gnt,
    output logic [N_REQ-1:0]              rvalid,
    output logic [CELL_W-1:0]             rdata,
    output logic [N_REQ-1:0]              err,
    output logic [BOARD_ADDR_W-1:0]       mem_addr,
    output logic [CELL_W-1:0]             mem_wdata,
    output logic                          mem_w_nr,
    input  logic [CELL_W-1:0]             mem_rdata
);

    localparam int IW  = $clog2(N_REQ);
    localparam int LCW = $clog2(MAX_LOCK);

    arb_state_t              state_q, state_d;
    logic [IW-1:0]           owner_q, owner_d;
    logic [IW-1:0]           rr_ptr_q, rr_ptr_d;
    logic [LCW-1:0]          lock_ctr_q, lock_ctr_d;
    logic [BOARD_ADDR_W-1:0] addr_hold_q, addr_hold_d;
    logic [CELL_W-1:0]       wdata_hold_q, wdata_hold_d;
    logic [N_REQ-1:0]        rvalid_q, rvalid_d;
    logic                    rd_ok_q, rd_ok_d;

    logic [N_REQ-1:0]        pick_onehot;
    logic [IW-1:0]           pick_idx;
    logic                    beat, beat_ok, range_bad;
    logic [IW-1:0]           sel;
    logic [BOARD_ADDR_W-1:0] sel_addr;
    logic [CELL_W-1:0]       sel_wdata;
    logic                    sel_w_nr;

    rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
        .req    (req),
        .ptr    (rr_ptr_q),
        .onehot (pick_onehot),
        .idx    (pick_idx)
    );

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        lock_ctr_d = lock_ctr_q;
        beat       = 1'b0;
        sel        = owner_q;

        // The exit cycle from OWN arbitrates exactly like IDLE, so no dead cycle.
        if (state_q == OWN && lock[owner_q] && lock_ctr_q != LCW'(MAX_LOCK - 1)) begin
            lock_ctr_d = lock_ctr_q + LCW'(1);
            beat       = req[owner_q];
        end else begin
            state_d    = IDLE;
            lock_ctr_d = '0;
            if (|pick_onehot) begin
                beat     = 1'b1;
                sel      = pick_idx;
                owner_d  = pick_idx;
                rr_ptr_d = (pick_idx == IW'(N_REQ - 1)) ? '0 : pick_idx + IW'(1);
                if (lock[pick_idx]) state_d = OWN;
            end
        end

        sel_addr  = '0;
        sel_wdata = '0;
        sel_w_nr  = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (sel == IW'(i)) begin
                sel_addr  = addr[i*BOARD_ADDR_W +: BOARD_ADDR_W];
                sel_wdata = wdata[i*CELL_W +: CELL_W];
                sel_w_nr  = w_nr[i];
            end
        end

        // Reset gates the combinational beat so outputs drop at once.
        beat_ok   = beat & rst;
        range_bad = ({1'b0, sel_addr[3:0]} >= 5'(X_SIZE)) ||
                    ({1'b0, sel_addr[7:4]} >= 5'(Y_SIZE));

        gnt       = {{(N_REQ-1){1'b0}}, beat_ok} << sel;
        err       = range_bad ? gnt : '0;
        mem_addr  = beat_ok ? sel_addr : addr_hold_q;
        mem_wdata = beat_ok ? sel_wdata : wdata_hold_q;
        mem_w_nr  = beat_ok & sel_w_nr & ~range_bad;

        addr_hold_d  = mem_addr;
        wdata_hold_d = mem_wdata;
        rvalid_d     = (beat_ok && !sel_w_nr) ? gnt : '0;
        rd_ok_d      = beat_ok & ~sel_w_nr & ~range_bad;

        rvalid = rvalid_q;
        rdata  = rd_ok_q ? mem_rdata : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            rr_ptr_q     <= '0;
            lock_ctr_q   <= '0;
            addr_hold_q  <= '0;
            wdata_hold_q <= '0;
            rvalid_q     <= '0;
            rd_ok_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            rr_ptr_q     <= rr_ptr_d;
            lock_ctr_q   <= lock_ctr_d;
            addr_hold_q  <= addr_hold_d;
            wdata_hold_q <= wdata_hold_d;
            rvalid_q     <= rvalid_d;
            rd_ok_q      <= rd_ok_d;
        end
    end

endmodule

// File: tb/tb_board_port_arbiter.sv
// Directed bench for board_port_arbiter with a synchronous-read board_mem model.
module tb_board_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req, lock, w_nr;
    logic [23:0] addr;
    logic [5:0]  wdata;
    logic [2:0]  gnt, rvalid, err;
    logic [1:0]  rdata;
    logic [7:0]  mem_addr;
    logic [1:0]  mem_wdata;
    logic        mem_w_nr;
    logic [1:0]  mem_rdata = 2'b00;

    logic [1:0]  bmem [256];
    logic        mem_init_done = 1'b0;

    int total = 0;
    int bad   = 0;
    int cnt;

    board_port_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .lock      (lock),
        .w_nr      (w_nr),
        .addr      (addr),
        .wdata     (wdata),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .err       (err),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_w_nr  (mem_w_nr),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int k = 0; k < 256; k++) bmem[k] <= 2'b00;
            bmem[8'h0C]   <= 2'b11;
            mem_init_done <= 1'b1;
        end else begin
            if (mem_w_nr) bmem[mem_addr] <= mem_wdata;
            mem_rdata <= bmem[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic drv(input int i, input logic r, input logic l, input logic w,
                       input logic [7:0] a, input logic [1:0] d);
        req[i]         = r;
        lock[i]        = l;
        w_nr[i]        = w;
        addr[i*8 +: 8] = a;
        wdata[i*2 +: 2] = d;
    endtask

    task automatic idle_all();
        for (int i = 0; i < 3; i++) drv(i, 1'b0, 1'b0, 1'b0, 8'h00, 2'b00);
    endtask

    initial begin
        rst = 1'b0;
        idle_all();

        // 1: reset hold, then round-robin rotation
        drv(0, 1'b1, 1'b0, 1'b0, 8'h01, 2'b00);
        drv(1, 1'b1, 1'b0, 1'b0, 8'h11, 2'b00);
        drv(2, 1'b1, 1'b0, 1'b0, 8'h22, 2'b00);
        @(negedge clk); #1;
        chk("t1_rst_gnt", gnt, 3'b000);
        chk("t1_rst_wnr", mem_w_nr, 1'b0);
        chk("t1_rst_rvalid", rvalid, 3'b000);
        chk("t1_rst_addr", mem_addr, 8'h00);
        rst = 1'b1; #1;
        chk("t1_g0", gnt, 3'b001);
        chk("t1_addr0", mem_addr, 8'h01);
        @(negedge clk); #1;
        chk("t1_g1", gnt, 3'b010);
        chk("t1_rv0", rvalid, 3'b001);
        @(negedge clk); #1;
        chk("t1_g2", gnt, 3'b100);
        chk("t1_rv1", rvalid, 3'b010);
        @(negedge clk); #1;
        chk("t1_g3", gnt, 3'b001);
        chk("t1_rv2", rvalid, 3'b100);
        @(negedge clk); idle_all(); #1;
        chk("t1_nogt", gnt, 3'b000);
        chk("t1_hold", mem_addr, 8'h01);

        // 2: write then read back through another requester
        @(negedge clk); drv(0, 1'b1, 1'b0, 1'b1, 8'h23, 2'b10); #1;
        chk("t2_wgnt", gnt, 3'b001);
        chk("t2_wnr", mem_w_nr, 1'b1);
        chk("t2_waddr", mem_addr, 8'h23);
        chk("t2_wdata", mem_wdata, 2'b10);
        @(negedge clk); idle_all(); drv(1, 1'b1, 1'b0, 1'b0, 8'h23, 2'b00); #1;
        chk("t2_rgnt", gnt, 3'b010);
        chk("t2_rwnr", mem_w_nr, 1'b0);
        @(negedge clk); idle_all(); #1;
        chk("t2_rvalid", rvalid, 3'b010);
        chk("t2_rdata", rdata, 2'b10);

        // 3: locked RMW by req0 while req1 waits
        @(negedge clk);
        drv(0, 1'b1, 1'b1, 1'b0, 8'h45, 2'b00);
        drv(1, 1'b1, 1'b0, 1'b0, 8'h23, 2'b00); #1;
        chk("t3_rd", gnt, 3'b001);
        @(negedge clk); drv(0, 1'b1, 1'b1, 1'b1, 8'h45, 2'b11); #1;
        chk("t3_wr", gnt, 3'b001);
        chk("t3_wnr", mem_w_nr, 1'b1);
        chk("t3_rv", rvalid, 3'b001);
        @(negedge clk); drv(0, 1'b0, 1'b1, 1'b0, 8'h45, 2'b00); #1;
        chk("t3_held", gnt, 3'b000);
        @(negedge clk); drv(0, 1'b0, 1'b0, 1'b0, 8'h45, 2'b00); #1;
        chk("t3_rel", gnt, 3'b010);
        @(negedge clk); idle_all(); #1;
        chk("t3_rv1", rvalid, 3'b010);
        chk("t3_rdata", rdata, 2'b10);
        chk("t3_mem45", bmem[8'h45], 2'b11);

        // 4: lock held forever by req2 gets cut after MAX_LOCK OWN cycles
        @(negedge clk);
        drv(0, 1'b1, 1'b0, 1'b0, 8'h01, 2'b00);
        drv(1, 1'b1, 1'b0, 1'b0, 8'h11, 2'b00);
        drv(2, 1'b1, 1'b1, 1'b0, 8'h33, 2'b00); #1;
        chk("t4_g2", gnt, 3'b100);
        cnt = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk); #1;
            if (gnt == 3'b100) cnt++;
        end
        chk("t4_owncnt", cnt, 15);
        @(negedge clk); #1;
        chk("t4_force0", gnt, 3'b001);
        @(negedge clk); #1;
        chk("t4_next1", gnt, 3'b010);
        @(negedge clk); #1;
        chk("t4_back2", gnt, 3'b100);
        @(negedge clk); idle_all(); #1;
        chk("t4_rel", gnt, 3'b000);

        // 5: out-of-range write and read
        @(negedge clk); drv(0, 1'b1, 1'b0, 1'b1, 8'hC0, 2'b01); #1;
        chk("t5_wgnt", gnt, 3'b001);
        chk("t5_werr", err, 3'b001);
        chk("t5_wnr", mem_w_nr, 1'b0);
        @(negedge clk); idle_all(); drv(1, 1'b1, 1'b0, 1'b0, 8'h0C, 2'b00); #1;
        chk("t5_rgnt", gnt, 3'b010);
        chk("t5_rerr", err, 3'b010);
        @(negedge clk); idle_all(); #1;
        chk("t5_rvalid", rvalid, 3'b010);
        chk("t5_rdata", rdata, 2'b00);
        chk("t5_noerr", err, 3'b000);
        chk("t5_memC0", bmem[8'hC0], 2'b00);

        // 6: async reset in the middle of an OWN with a read outstanding
        @(negedge clk); drv(2, 1'b1, 1'b1, 1'b0, 8'h45, 2'b00); #1;
        chk("t6_g2", gnt, 3'b100);
        @(negedge clk); #1;
        chk("t6_own", gnt, 3'b100);
        chk("t6_rv", rvalid, 3'b100);
        chk("t6_rd", rdata, 2'b11);
        #2 rst = 1'b0; #1;
        chk("t6_rst_gnt", gnt, 3'b000);
        chk("t6_rst_rv", rvalid, 3'b000);
        chk("t6_rst_rd", rdata, 2'b00);
        chk("t6_rst_addr", mem_addr, 8'h00);
        @(negedge clk); #1;
        chk("t6_lost_rv", rvalid, 3'b000);
        @(negedge clk);
        drv(0, 1'b1, 1'b0, 1'b0, 8'h01, 2'b00);
        drv(1, 1'b1, 1'b0, 1'b0, 8'h11, 2'b00);
        drv(2, 1'b1, 1'b0, 1'b0, 8'h22, 2'b00);
        rst = 1'b1; #1;
        chk("t6_ptr0", gnt, 3'b001);
        @(negedge clk); #1;
        chk("t6_idle", gnt, 3'b010);
        chk("t6_rv0", rvalid, 3'b001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
